score_playback_sequencer: RTL and testbench
===========================================

// Module: score_playback_sequencer
// PURPOSE
//  Transport controller for score playback: steps an address through the score ROM
//  (music_score), times each entry's duration in 1 ms ticks, and drives the tone
//  generator. Handles play/pause/stop, an articulation gap, rests, end-of-song and looping.
//  Sits between the front-panel/game FSM and the ROM + buzzer driver.
// PARAMETERS
//  ADDR_W   8   score ROM address width
//  LEN_W    16  duration field width (ms)
//  GAP_MS   20  trailing silent ms carved from each note (0 = legato)
// PORTS
//  clk_1ms      in   1       clock; one cycle = 1 ms
//  rst          in   1       synchronous, active-high reset
//  play         in   1       start (IDLE/DONE) or resume (PAUSED); 1-cycle pulse
//  pause        in   1       hold current note; 1-cycle pulse
//  stop         in   1       abort, return to address 0; 1-cycle pulse
//  loop_en      in   1       on end marker, restart at address 0 instead of finishing
//  rom_addr     out  ADDR_W  score ROM address
//  rom_data     in   24      {len[23:8], note[7:4], octave[3:0]}; combinational ROM read
//  cur_note     out  4       latched note; 0 = rest
//  cur_octave   out  4       latched octave
//  remaining    out  LEN_W   ms left in current entry
//  tone_en      out  1       buzzer enable
//  note_start   out  1       1-cycle pulse when an entry is latched
//  song_done    out  1       1-cycle pulse on entering DONE
//  busy         out  1       high in LOAD/SOUND/PAUSED
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr, cur_note, cur_octave, remaining = 0; all 1-bit outputs 0.
//  Command priority, same cycle: stop > pause > play. Commands not legal in the current
//   state are ignored.
//  IDLE:   rom_addr=0. play -> LOAD.
//  LOAD:   exactly 1 cycle, tone_en=0. Sample rom_data at rom_addr.
//          len==0 (end marker):
//            - loop_en=1 and rom_addr!=0 -> rom_addr<=0, stay LOAD.
//            - otherwise -> DONE, song_done=1.
//          Else latch note/octave, remaining<=len, note_start=1 -> SOUND.
//  SOUND:  remaining decrements by 1 each cycle.
//          tone_en = (cur_note!=0) && (remaining > GAP_MS); registered, based on the
//           current-cycle remaining value.
//          remaining==1 -> remaining<=0. Then:
//            - rom_addr != 2^ADDR_W-1 -> rom_addr++, LOAD.
//            - rom_addr == 2^ADDR_W-1 -> treated as an end marker (loop/DONE rules as
//              LOAD), no wrap.
//          pause -> PAUSED.
//  Timing: each non-end entry occupies exactly len+1 cycles (1 LOAD + len SOUND).
//  PAUSED: remaining, rom_addr, note and octave frozen; tone_en=0. play -> SOUND.
//  DONE:   rom_addr holds; tone_en=0, busy=0. play -> rom_addr<=0, LOAD.
//  stop:   from any state -> IDLE, rom_addr=0, remaining=0, tone_en=0.
//          No song_done pulse.
//  Rests:  note==0 are timed identically to notes with tone_en held low.
//  If len <= GAP_MS, the note is silent for its whole duration.
//  rst mid-note has the same effect as reset; it overrides all commands.
// STRUCTURE
//  Shared package score_pkg:
//   - state encoding (IDLE, LOAD, SOUND, PAUSED, DONE)
//   - field slices LEN_MSB/LSB, NOTE_MSB/LSB, OCT_MSB/LSB
//   - END_LEN=0
//  Sub-module note_duration_counter: load / decrement / hold, with an is_one flag.
//  FSM and address register live in the top module. ROM instantiated outside.
// TESTING
//  1. ROM {3,5,4},{0}, GAP_MS=1; play at cycle 0 -> LOAD at cycle 1, note_start at 2,
//     tone_en high 2 cycles then low 1, LOAD addr1, song_done, busy=0.
//  2. Note len=50; pause at remaining=30 for 10 cycles, then play -> remaining still 30,
//     note ends 30 cycles after resume.
//  3. loop_en=1, 2-note score + end marker -> rom_addr sequence 0,1,2,0,1,...
//     Never song_done. Clearing loop_en -> DONE at next marker.
//  4. stop and pause in the same cycle during SOUND -> IDLE, rom_addr=0, tone_en=0
//     next cycle.
//  5. rst asserted mid-SOUND with play also high -> all outputs 0, state IDLE.
//     Rest entry {100,0,0} -> 101 cycles, tone_en never high.
//  6. All 256 entries non-zero -> after addr 255 completes: DONE (loop_en=0),
//     or addr 0 (loop_en=1).

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and score-word field layout for the playback sequencer.
// A score word is {len[23:8], note[7:4], octave[3:0]}; len==0 marks the end.
package score_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SOUND,
        ST_PAUSED,
        ST_DONE
    } state_t;

    localparam int ROM_W    = 24;
    localparam int LEN_MSB  = 23;
    localparam int LEN_LSB  = 8;
    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 4;
    localparam int OCT_MSB  = 3;
    localparam int OCT_LSB  = 0;

    localparam logic [LEN_MSB-LEN_LSB:0] END_LEN = '0;

    function automatic logic is_end(logic [ROM_W-1:0] word);
        return word[LEN_MSB:LEN_LSB] == END_LEN;
    endfunction

endpackage

// File: rtl/score_playback_sequencer_if.sv
// Transport commands, score ROM bus and tone-generator outputs.
// master = sequencer side, slave = panel/ROM/buzzer side.
interface score_playback_sequencer_if
    import score_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
);
    logic              play;
    logic              pause;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_data;
    logic [3:0]        cur_note;
    logic [3:0]        cur_octave;
    logic [LEN_W-1:0]  remaining;
    logic              tone_en;
    logic              note_start;
    logic              song_done;
    logic              busy;

    modport master (
        input  play, pause, stop, loop_en, rom_data,
        output rom_addr, cur_note, cur_octave, remaining,
        output tone_en, note_start, song_done, busy
    );

    modport slave (
        output play, pause, stop, loop_en, rom_data,
        input  rom_addr, cur_note, cur_octave, remaining,
        input  tone_en, note_start, song_done, busy
    );

endinterface

// File: rtl/note_duration_counter.sv
// Millisecond down-counter for the current score entry.
// Priority: clear > load > decrement; never goes below zero.
module note_duration_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic [W-1:0] count,
    output logic         is_one
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= din;
        end else if (dec && count != '0) begin
            count <= count - ONE;
        end
    end

    assign is_one = (count == ONE);

endmodule

// File: rtl/score_playback_sequencer.sv
// Score transport: steps the ROM address, times entries in 1 ms ticks,
// and gates the buzzer with an articulation gap at the tail of each note.
module score_playback_sequencer
    import score_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16,
    parameter int GAP_MS = 20
) (
    input logic                       clk_1ms,
    input logic                       rst,
    score_playback_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [LEN_W-1:0]  GAP       = LEN_W'(GAP_MS);
    localparam logic [LEN_W-1:0]  ONE       = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             rem_is_one;
    logic [LEN_W-1:0] rom_len;
    logic [3:0]       rom_note;
    logic [3:0]       rom_oct;
    logic             rom_end;
    logic             cnt_load;
    logic             cnt_dec;

    assign rom_len  = LEN_W'(bus.rom_data[LEN_MSB:LEN_LSB]);
    assign rom_note = bus.rom_data[NOTE_MSB:NOTE_LSB];
    assign rom_oct  = bus.rom_data[OCT_MSB:OCT_LSB];
    assign rom_end  = is_end(bus.rom_data);

    // pause freezes the count in the very cycle it is sampled
    assign cnt_load = (state == ST_LOAD) && !bus.stop && !rom_end;
    assign cnt_dec  = (state == ST_SOUND) && !bus.stop && !bus.pause;

    note_duration_counter #(.W(LEN_W)) u_cnt (
        .clk    (clk_1ms),
        .rst    (rst),
        .clr    (bus.stop),
        .load   (cnt_load),
        .dec    (cnt_dec),
        .din    (rom_len),
        .count  (remaining),
        .is_one (rem_is_one)
    );

    assign bus.remaining = remaining;

    // tone_en is registered from the value remaining will hold next cycle
    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.rom_addr   <= '0;
            bus.cur_note   <= '0;
            bus.cur_octave <= '0;
            bus.tone_en    <= 1'b0;
            bus.note_start <= 1'b0;
            bus.song_done  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.note_start <= 1'b0;
            bus.song_done  <= 1'b0;
            if (bus.stop) begin
                state        <= ST_IDLE;
                bus.rom_addr <= '0;
                bus.tone_en  <= 1'b0;
                bus.busy     <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        bus.rom_addr <= '0;
                        if (bus.play) begin
                            state    <= ST_LOAD;
                            bus.busy <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (rom_end) begin
                            if (bus.loop_en && bus.rom_addr != '0) begin
                                bus.rom_addr <= '0;
                            end else begin
                                state         <= ST_DONE;
                                bus.song_done <= 1'b1;
                                bus.busy      <= 1'b0;
                            end
                        end else begin
                            state          <= ST_SOUND;
                            bus.cur_note   <= rom_note;
                            bus.cur_octave <= rom_oct;
                            bus.note_start <= 1'b1;
                            bus.tone_en    <= (rom_note != '0) && (rom_len > GAP);
                        end
                    end
                    ST_SOUND: begin
                        if (bus.pause) begin
                            state       <= ST_PAUSED;
                            bus.tone_en <= 1'b0;
                        end else if (rem_is_one) begin
                            bus.tone_en <= 1'b0;
                            if (bus.rom_addr != LAST_ADDR) begin
                                bus.rom_addr <= bus.rom_addr + 1'b1;
                                state        <= ST_LOAD;
                            end else if (bus.loop_en) begin
                                bus.rom_addr <= '0;
                                state        <= ST_LOAD;
                            end else begin
                                state         <= ST_DONE;
                                bus.song_done <= 1'b1;
                                bus.busy      <= 1'b0;
                            end
                        end else begin
                            bus.tone_en <= (bus.cur_note != '0)
                                        && ((remaining - ONE) > GAP);
                        end
                    end
                    ST_PAUSED: begin
                        if (bus.play) begin
                            state       <= ST_SOUND;
                            bus.tone_en <= (bus.cur_note != '0)
                                        && (remaining > GAP);
                        end
                    end
                    ST_DONE: begin
                        if (bus.play) begin
                            state        <= ST_LOAD;
                            bus.rom_addr <= '0;
                            bus.busy     <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_playback_sequencer.sv
// Directed bench: stimulus pushes expected note/done events into a queue,
// a negedge monitor pops and compares whenever note_start or song_done fires.
module tb_score_playback_sequencer;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;
    localparam int GAP_MS = 1;

    typedef struct {
        bit done;
        int addr;
        int note;
        int oct;
        int rem;
        int tone;
    } exp_t;

    logic        clk_1ms = 1'b0;
    logic        rst     = 1'b1;
    logic [23:0] rom [256];
    exp_t        q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    score_playback_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    score_playback_sequencer #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .GAP_MS (GAP_MS)
    ) dut (
        .clk_1ms (clk_1ms),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_1ms = ~clk_1ms;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk_1ms);
        #1;
    endtask

    task automatic push_note(int addr, int note, int oct, int rem, int tone);
        exp_t e;
        e.done = 1'b0;
        e.addr = addr;
        e.note = note;
        e.oct  = oct;
        e.rem  = rem;
        e.tone = tone;
        q.push_back(e);
    endtask

    task automatic push_done(int addr);
        exp_t e;
        e.done = 1'b1;
        e.addr = addr;
        e.note = 0;
        e.oct  = 0;
        e.rem  = 0;
        e.tone = 0;
        q.push_back(e);
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
    endtask

    always @(negedge clk_1ms) begin
        if (!rst && (bus.note_start || bus.song_done)) begin
            exp_t e;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got note_start=%0b song_done=%0b, required none",
                         bus.note_start, bus.song_done);
            end else begin
                e = q.pop_front();
                check("ev_is_done", 32'(bus.song_done), 32'(e.done));
                check("ev_addr", 32'(bus.rom_addr), e.addr);
                if (!e.done) begin
                    check("ev_note", 32'(bus.cur_note), e.note);
                    check("ev_oct", 32'(bus.cur_octave), e.oct);
                    check("ev_rem", 32'(bus.remaining), e.rem);
                    check("ev_tone", 32'(bus.tone_en), e.tone);
                end else begin
                    check("ev_busy", 32'(bus.busy), 0);
                end
            end
        end
    end

    int a3 [12] = '{0, 0, 0, 1, 1, 2, 0, 0, 0, 1, 1, 2};

    initial begin
        logic [2:0] tv;
        int tone_hi;
        int a1;
        int dn;
        bus.play    = 1'b0;
        bus.pause   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = '0;

        // reset state
        cyc(3);
        check("rst_addr", 32'(bus.rom_addr), 0);
        check("rst_note", 32'({bus.cur_note, bus.cur_octave}), 0);
        check("rst_rem", 32'(bus.remaining), 0);
        check("rst_bits", 32'({bus.tone_en, bus.note_start,
                               bus.song_done, bus.busy}), 0);
        rst = 1'b0;
        cyc(1);

        // 1: {3,5,4},{0}
        rom[0] = 24'h000354;
        rom[1] = 24'h000000;
        push_note(0, 5, 4, 3, 1);
        push_done(1);
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        check("t1_load_busy", 32'(bus.busy), 1);
        check("t1_load_tone", 32'(bus.tone_en), 0);
        check("t1_load_ns", 32'(bus.note_start), 0);
        cyc(1);
        check("t1_ns", 32'(bus.note_start), 1);
        tv = 3'b011;
        for (int i = 0; i < 3; i++) begin
            check("t1_tone", 32'(bus.tone_en), 32'(tv[i]));
            check("t1_rem", 32'(bus.remaining), 3 - i);
            cyc(1);
        end
        check("t1_load1_addr", 32'(bus.rom_addr), 1);
        check("t1_load1_busy", 32'(bus.busy), 1);
        cyc(1);
        check("t1_done", 32'(bus.song_done), 1);
        check("t1_idle_busy", 32'(bus.busy), 0);

        // 2: pause at remaining=30 for 10 cycles
        pulse_stop();
        rom[0] = 24'h003212;
        push_note(0, 1, 2, 50, 1);
        push_done(1);
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        cyc(21);
        check("t2_rem_pre", 32'(bus.remaining), 30);
        bus.pause = 1'b1;
        cyc(1);
        bus.pause = 1'b0;
        check("t2_rem_pause", 32'(bus.remaining), 30);
        check("t2_tone_pause", 32'(bus.tone_en), 0);
        check("t2_busy_pause", 32'(bus.busy), 1);
        cyc(10);
        check("t2_rem_held", 32'(bus.remaining), 30);
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        check("t2_rem_resume", 32'(bus.remaining), 30);
        check("t2_tone_resume", 32'(bus.tone_en), 1);
        cyc(29);
        check("t2_last_rem", 32'(bus.remaining), 1);
        check("t2_last_addr", 32'(bus.rom_addr), 0);
        cyc(1);
        check("t2_next_addr", 32'(bus.rom_addr), 1);
        check("t2_next_rem", 32'(bus.remaining), 0);
        cyc(1);
        check("t2_end_busy", 32'(bus.busy), 0);

        // 3: looping two entries, then clear loop_en
        pulse_stop();
        rom[0] = 24'h000231;
        rom[1] = 24'h000100;
        rom[2] = 24'h000000;
        push_note(0, 3, 1, 2, 1);
        push_note(1, 0, 0, 1, 0);
        push_note(0, 3, 1, 2, 1);
        push_note(1, 0, 0, 1, 0);
        push_done(2);
        bus.loop_en = 1'b1;
        bus.play    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            bus.play = 1'b0;
            check("t3_addr_seq", 32'(bus.rom_addr), a3[i]);
            if (i == 8) bus.loop_en = 1'b0;
        end
        cyc(2);
        check("t3_done_busy", 32'(bus.busy), 0);
        check("t3_done_addr", 32'(bus.rom_addr), 2);

        // 4: stop and pause together during SOUND
        pulse_stop();
        rom[0] = 24'h000A73;
        rom[1] = 24'h000000;
        push_note(0, 7, 3, 10, 1);
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        cyc(3);
        bus.stop  = 1'b1;
        bus.pause = 1'b1;
        cyc(1);
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_addr", 32'(bus.rom_addr), 0);
        check("t4_tone", 32'(bus.tone_en), 0);
        check("t4_rem", 32'(bus.remaining), 0);
        cyc(3);
        check("t4_stay_idle", 32'(bus.busy), 0);

        // 5a: rst mid-SOUND with play high
        rom[0] = 24'h000895;
        push_note(0, 9, 5, 8, 1);
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        cyc(3);
        rst      = 1'b1;
        bus.play = 1'b1;
        cyc(1);
        rst      = 1'b0;
        bus.play = 1'b0;
        check("t5_note", 32'({bus.cur_note, bus.cur_octave}), 0);
        check("t5_rem", 32'(bus.remaining), 0);
        check("t5_bits", 32'({bus.tone_en, bus.note_start,
                              bus.song_done, bus.busy}), 0);
        check("t5_addr", 32'(bus.rom_addr), 0);
        cyc(2);
        check("t5_idle", 32'(bus.busy), 0);

        // 5b: 100 ms rest, then a 1 ms note shorter than the gap
        rom[0] = 24'h006400;
        rom[1] = 24'h000133;
        rom[2] = 24'h000000;
        push_note(0, 0, 0, 100, 0);
        push_note(1, 3, 3, 1, 0);
        push_done(2);
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        tone_hi = 0;
        a1 = -1;
        dn = -1;
        for (int c = 1; c <= 120 && dn < 0; c++) begin
            if (bus.tone_en) tone_hi++;
            if (a1 < 0 && bus.rom_addr == 8'd1) a1 = c;
            if (bus.song_done) dn = c;
            if (dn < 0) cyc(1);
        end
        check("t5_rest_tone", tone_hi, 0);
        check("t5_rest_len", a1, 102);
        check("t5_done_cyc", dn, 105);

        // 6: full 256-entry score, no loop then loop
        pulse_stop();
        for (int i = 0; i < 256; i++) begin
            rom[i] = {16'd1, 4'(i % 15 + 1), 4'(i % 16)};
            push_note(i, i % 15 + 1, i % 16, 1, 0);
        end
        push_done(255);
        bus.play = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        dn = -1;
        for (int c = 1; c <= 600 && dn < 0; c++) begin
            if (bus.song_done) dn = c;
            if (dn < 0) cyc(1);
        end
        check("t6_done_cyc", dn, 513);
        check("t6_done_addr", 32'(bus.rom_addr), 255);
        check("t6_done_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 256; i++) push_note(i, i % 15 + 1, i % 16, 1, 0);
        push_note(0, 1, 0, 1, 0);
        bus.loop_en = 1'b1;
        bus.play    = 1'b1;
        cyc(1);
        bus.play = 1'b0;
        for (int c = 2; c <= 513; c++) begin
            cyc(1);
            if (c == 512) check("t6_loop_last", 32'(bus.rom_addr), 255);
        end
        check("t6_loop_wrap", 32'(bus.rom_addr), 0);
        check("t6_loop_busy", 32'(bus.busy), 1);
        cyc(1);
        pulse_stop();
        bus.loop_en = 1'b0;

        cyc(3);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
